// File: rtl/cache_fill_ctrl.sv
// Direct-mapped cache lookup / 4-word line fill controller between the CPU load port and the array.
// Optional saturating hit/miss counters are enabled with the CACHE_STATS_EN macro.
module cache_fill_ctrl #(
    parameter int WORD_W  = 32,
    parameter int TAG_W   = 3,
    parameter int INDEX_W = 10,
    parameter int OFF_W   = 2,
    parameter int ADDR_W  = TAG_W + INDEX_W + OFF_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cpu_req,
    input  logic [ADDR_W-1:0]   cpu_addr,
    output logic                cpu_busy,
    output logic                cpu_valid,
    output logic [WORD_W-1:0]   cpu_rdata,
    output logic [TAG_W-1:0]    cache_tag,
    output logic [INDEX_W-1:0]  cache_index,
    output logic [OFF_W-1:0]    cache_offset,
    input  logic                cache_hit,
    input  logic [WORD_W-1:0]   cache_rdata,
    output logic                fill_we,
    output logic [4*WORD_W-1:0] fill_line,
    output logic                mm_rd,
    output logic [ADDR_W-1:0]   mm_addr,
    input  logic                mm_ack,
    input  logic [WORD_W-1:0]   mm_rdata
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_FILL   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } state_t;

    state_t                   state_r, state_nxt_s;
    logic [OFF_W-1:0]         wc_r, wc_nxt_s;
    logic [3:0][WORD_W-1:0]   line_r, line_nxt_s;
    logic [TAG_W-1:0]         tag_nxt_s;
    logic [INDEX_W-1:0]       index_nxt_s;
    logic [OFF_W-1:0]         off_nxt_s;
    logic [WORD_W-1:0]        rdata_nxt_s;
    logic [ADDR_W-1:0]        mm_addr_nxt_s;

    // word0 sits in the top slot of the line, so slot index is the bit-inverted word number
    assign fill_line = line_r;

    // next-state and next-output computation
    always_comb begin
        state_nxt_s   = state_r;
        wc_nxt_s      = wc_r;
        line_nxt_s    = line_r;
        tag_nxt_s     = cache_tag;
        index_nxt_s   = cache_index;
        off_nxt_s     = cache_offset;
        rdata_nxt_s   = cpu_rdata;
        mm_addr_nxt_s = mm_addr;
        case (state_r)
            ST_IDLE: begin
                if (cpu_req) begin
                    {tag_nxt_s, index_nxt_s, off_nxt_s} = cpu_addr;
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (cache_hit) begin
                    rdata_nxt_s = cache_rdata;
                    state_nxt_s = ST_RESP;
                end else begin
                    wc_nxt_s    = {OFF_W{1'b0}};
                    state_nxt_s = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mm_ack) begin
                    line_nxt_s[~wc_r] = mm_rdata;
                    wc_nxt_s          = wc_r + OFF_W'(1);
                    if (&wc_r) begin
                        state_nxt_s = ST_WRITE;
                    end else begin
                        state_nxt_s = ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_WRITE: begin
                rdata_nxt_s = line_r[~cache_offset];
                state_nxt_s = ST_RESP;
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (state_nxt_s == ST_FILL) begin
            mm_addr_nxt_s = {tag_nxt_s, index_nxt_s, wc_nxt_s};
        end else begin
            mm_addr_nxt_s = mm_addr;
        end
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            wc_r         <= {OFF_W{1'b0}};
            line_r       <= '0;
            cache_tag    <= {TAG_W{1'b0}};
            cache_index  <= {INDEX_W{1'b0}};
            cache_offset <= {OFF_W{1'b0}};
            cpu_rdata    <= {WORD_W{1'b0}};
            cpu_busy     <= 1'b0;
            cpu_valid    <= 1'b0;
            fill_we      <= 1'b0;
            mm_rd        <= 1'b0;
            mm_addr      <= {ADDR_W{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            wc_r         <= wc_nxt_s;
            line_r       <= line_nxt_s;
            cache_tag    <= tag_nxt_s;
            cache_index  <= index_nxt_s;
            cache_offset <= off_nxt_s;
            cpu_rdata    <= rdata_nxt_s;
            cpu_busy     <= (state_nxt_s != ST_IDLE);
            cpu_valid    <= (state_nxt_s == ST_RESP);
            fill_we      <= (state_nxt_s == ST_WRITE);
            mm_rd        <= (state_nxt_s == ST_FILL);
            mm_addr      <= mm_addr_nxt_s;
        end
    end

`ifdef CACHE_STATS_EN
    // saturating lookup-outcome counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
        end else if (state_r == ST_LOOKUP) begin
            if (cache_hit) begin
                if (hit_count != 32'hFFFF_FFFF) begin
                    hit_count <= hit_count + 32'd1;
                end
            end else begin
                if (miss_count != 32'hFFFF_FFFF) begin
                    miss_count <= miss_count + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: per-cycle scoreboard built from transaction latency rules.
module tb_cache_fill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         cpu_req;
    logic [14:0]  cpu_addr;
    logic         cpu_busy;
    logic         cpu_valid;
    logic [31:0]  cpu_rdata;
    logic [2:0]   cache_tag;
    logic [9:0]   cache_index;
    logic [1:0]   cache_offset;
    logic         cache_hit;
    logic [31:0]  cache_rdata;
    logic         fill_we;
    logic [127:0] fill_line;
    logic         mm_rd;
    logic [14:0]  mm_addr;
    logic         mm_ack;
    logic [31:0]  mm_rdata;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    cache_fill_ctrl dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_busy(cpu_busy), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .cache_tag(cache_tag), .cache_index(cache_index), .cache_offset(cache_offset),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .fill_we(fill_we), .fill_line(fill_line),
        .mm_rd(mm_rd), .mm_addr(mm_addr), .mm_ack(mm_ack), .mm_rdata(mm_rdata)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected outputs for one cycle, keyed by number of rising edges seen
    typedef struct packed {
        logic         clr;
        logic         busy;
        logic         valid;
        logic         mmrd;
        logic         we;
        logic [14:0]  caddr;
        logic [14:0]  addr;
        logic [31:0]  rdata;
        logic [127:0] line;
    } exp_t;

    exp_t exp_q [int];
    int   checks = 0;
    int   errors = 0;
    int   model_hits = 0;
    int   model_misses = 0;
    logic [31:0] model_rdata = 32'd0;

    int          obs_valid_cyc, obs_valid_cnt, obs_we_cnt, obs_mmrd_cnt;
    logic [31:0] obs_rdata;
    logic [127:0] obs_line;
    logic [14:0] obs_addr_q [$];

    function automatic exp_t get(int c);
        exp_t e;
        e = '0;
        if (exp_q.exists(c)) e = exp_q[c];
        return e;
    endfunction

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %0h, expected %0h", nm, cyc, got, expv);
        end
    endtask

    task automatic obs_clear();
        obs_valid_cyc = 0; obs_valid_cnt = 0; obs_we_cnt = 0; obs_mmrd_cnt = 0;
        obs_rdata = 32'd0; obs_line = 128'd0;
        obs_addr_q.delete();
    endtask

    // compare process: every cycle against the scoreboard
    initial begin : compare
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                e = get(cyc);
                if (e.clr) model_rdata = 32'd0;
                if (e.valid) model_rdata = e.rdata;
                chk("cpu_busy",  cpu_busy,  e.busy);
                chk("cpu_valid", cpu_valid, e.valid);
                chk("mm_rd",     mm_rd,     e.mmrd);
                chk("fill_we",   fill_we,   e.we);
                chk("cpu_rdata", cpu_rdata, model_rdata);
                if (e.mmrd) chk("mm_addr", mm_addr, e.addr);
                if (e.we)   chk("fill_line", fill_line, e.line);
                if (e.busy) chk("cache_addr", {cache_tag, cache_index, cache_offset}, e.caddr);
                if (e.clr) begin
                    chk("rst_fill_line",  fill_line, 128'd0);
                    chk("rst_cache_addr", {cache_tag, cache_index, cache_offset}, 15'd0);
                    chk("rst_mm_addr",    mm_addr, 15'd0);
                end
                if (cpu_valid) begin
                    obs_valid_cyc = cyc; obs_valid_cnt++; obs_rdata = cpu_rdata;
                end
                if (fill_we) begin
                    obs_we_cnt++; obs_line = fill_line;
                end
                if (mm_rd) begin
                    obs_mmrd_cnt++;
                    if (obs_addr_q.size() == 0 || obs_addr_q[$] != mm_addr) obs_addr_q.push_back(mm_addr);
                end
            end
        end
    end

    // call at a falling edge: two reset edges follow, future expectations are discarded
    task automatic do_reset();
        int c;
        int ks [$];
        exp_t e;
        c = cyc;
        foreach (exp_q[k]) if (k > c) ks.push_back(k);
        foreach (ks[i]) exp_q.delete(ks[i]);
        for (int i = 1; i <= 2; i++) begin
            e = '0; e.clr = 1'b1; exp_q[c + i] = e;
        end
        rst = 1'b1; cpu_req = 1'b0; mm_ack = 1'b0;
        model_hits = 0; model_misses = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_txn(input logic [14:0] addr, input logic hit, input logic [31:0] hdata,
                          input logic [31:0] w [4], input int g [4], input logic hold,
                          input int abort_k, output int e0);
        int   a [4];
        int   vcyc, c, kk;
        exp_t e;
        @(negedge clk);
        e0 = cyc + 1;
        cpu_req = 1'b1; cpu_addr = addr;
        cache_hit = 1'($urandom_range(0, 1)); cache_rdata = $urandom;
        mm_ack = 1'b0; mm_rdata = $urandom;
        if (hit) model_hits++; else model_misses++;
        a[0] = e0 + 2 + g[0];
        for (int k = 1; k < 4; k++) a[k] = a[k-1] + g[k] + 1;
        vcyc = hit ? e0 + 1 : a[3] + 1;
        for (c = e0; c <= vcyc; c++) begin
            e = get(c); e.busy = 1'b1; e.caddr = addr; exp_q[c] = e;
        end
        e = get(vcyc); e.valid = 1'b1; e.rdata = hit ? hdata : w[addr[1:0]]; exp_q[vcyc] = e;
        if (!hit) begin
            for (c = e0 + 1; c < a[3]; c++) begin
                kk = 0;
                for (int k = 0; k < 4; k++) if (a[k] <= c) kk++;
                e = get(c); e.mmrd = 1'b1; e.addr = {addr[14:2], kk[1:0]}; exp_q[c] = e;
            end
            e = get(a[3]); e.we = 1'b1; e.line = {w[0], w[1], w[2], w[3]}; exp_q[a[3]] = e;
        end
        do begin
            @(negedge clk);
            c = cyc;
            if (hold) cpu_addr = 15'($urandom); else cpu_req = 1'b0;
            cache_hit   = (c == e0) ? hit : 1'($urandom_range(0, 1));
            cache_rdata = (c == e0) ? hdata : $urandom;
            if (!hit && abort_k > 0 && c == a[abort_k-1]) begin
                do_reset();
                return;
            end
            mm_ack = 1'b0; mm_rdata = $urandom;
            if (!hit && c >= e0 + 1 && c < a[3]) begin
                for (int k = 0; k < 4; k++) if (a[k] == c + 1) begin
                    mm_ack = 1'b1; mm_rdata = w[k];
                end
            end else begin
                mm_ack = ($urandom_range(0, 3) == 0);
            end
        end while (c != vcyc);
    endtask

    task automatic settle();
        @(negedge clk);
        cpu_req = 1'b0; mm_ack = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not complete, got %0d checks, expected completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] w [4];
        int          g [4];
        int          e0;
        logic [14:0] ra;
        logic        rh, rhold, prev_hold;
        exp_t        e;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = 15'd0; cache_hit = 1'b0;
        cache_rdata = 32'd0; mm_ack = 1'b0; mm_rdata = 32'd0;
        for (int i = 1; i <= 3; i++) begin
            e = '0; e.clr = 1'b1; exp_q[i] = e;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // miss 0x1234, ack every cycle
        w = '{32'hA0, 32'hA1, 32'hA2, 32'hA3}; g = '{0, 0, 0, 0};
        obs_clear();
        do_txn(15'h1234, 1'b0, 32'd0, w, g, 1'b0, -1, e0);
        settle();
        chk("lit_miss_latency", obs_valid_cyc - e0 + 1, 7);
        chk("lit_miss_rdata", obs_rdata, 32'hA0);
        chk("lit_miss_line", obs_line, 128'h000000A0_000000A1_000000A2_000000A3);
        chk("lit_miss_addr_cnt", obs_addr_q.size(), 4);
        for (int i = 0; i < obs_addr_q.size(); i++) chk("lit_miss_addr_seq", obs_addr_q[i], 15'h1234 + 15'(i));

        // hit
        obs_clear();
        do_txn(15'h2ABD, 1'b1, 32'hDEADBEEF, w, g, 1'b0, -1, e0);
        settle();
        chk("lit_hit_latency", obs_valid_cyc - e0 + 1, 2);
        chk("lit_hit_rdata", obs_rdata, 32'hDEADBEEF);
        chk("lit_hit_no_mm_rd", obs_mmrd_cnt, 0);

        // miss offset 3, three idle cycles between words
        w = '{32'hB0, 32'hB1, 32'hB2, 32'hB3}; g = '{0, 3, 3, 3};
        obs_clear();
        do_txn(15'h5A7B, 1'b0, 32'd0, w, g, 1'b0, -1, e0);
        settle();
        chk("lit_slow_latency", obs_valid_cyc - e0 + 1, 16);
        chk("lit_slow_rdata", obs_rdata, 32'hB3);
        chk("lit_slow_we_pulses", obs_we_cnt, 1);
        chk("lit_slow_mm_rd_cycles", obs_mmrd_cnt, 13);
        chk("lit_slow_words", obs_addr_q.size(), 4);

        // cpu_req held high across a miss and a hit
        w = '{32'hC0, 32'hC1, 32'hC2, 32'hC3}; g = '{0, 1, 0, 2};
        obs_clear();
        do_txn(15'h0F0E, 1'b0, 32'd0, w, g, 1'b1, -1, e0);
        do_txn(15'h0F0D, 1'b1, 32'h1357_9BDF, w, g, 1'b1, -1, e0);
        settle();
        chk("lit_hold_txns", obs_valid_cnt, 2);

        // reset after two acks, then the same miss again
        w = '{32'hD0, 32'hD1, 32'hD2, 32'hD3}; g = '{0, 0, 0, 0};
        obs_clear();
        do_txn(15'h6C26, 1'b0, 32'd0, w, g, 1'b0, 2, e0);
        settle();
        chk("lit_abort_no_we", obs_we_cnt, 0);
        obs_clear();
        do_txn(15'h6C26, 1'b0, 32'd0, w, g, 1'b0, -1, e0);
        settle();
        chk("lit_refill_word0", obs_addr_q[0], 15'h6C24);
        chk("lit_refill_rdata", obs_rdata, 32'hD2);

        // randomized traffic
        prev_hold = 1'b0;
        for (int t = 0; t < 150; t++) begin
            ra = 15'($urandom); rh = 1'($urandom_range(0, 1)); rhold = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < 4; k++) begin
                w[k] = $urandom; g[k] = $urandom_range(0, 3);
            end
            if (!prev_hold && $urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    mm_ack = ($urandom_range(0, 1) == 0); mm_rdata = $urandom;
                    cache_hit = 1'($urandom_range(0, 1));
                end
            end
            do_txn(ra, rh, $urandom, w, g, rhold, -1, e0);
            prev_hold = rhold;
        end
        settle();
        repeat (3) @(negedge clk);

`ifdef CACHE_STATS_EN
        chk("stats_hits_random", hit_count, model_hits);
        chk("stats_misses_random", miss_count, model_misses);
        do_reset();
        g = '{0, 0, 0, 0};
        for (int i = 0; i < 5; i++) begin
            do_txn(15'($urandom), (i < 3), $urandom, w, g, 1'b0, -1, e0);
        end
        settle();
        chk("lit_stats_hits", hit_count, 32'd3);
        chk("lit_stats_misses", miss_count, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
